// File: rtl/analog_probe_scheduler_if.sv
// Bundle of request, response and probe signals shared between measurement
// clients (master) and the probe scheduler (slave).
interface analog_probe_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int NODE_W = 4,
    parameter int CNT_W  = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_kind;
    logic [N_REQ*NODE_W-1:0] req_node;
    logic [N_REQ-1:0]        req_ready;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_kind;
    real                     rsp_value;

    logic [NODE_W-1:0]       probe_node;
    logic                    probe_voltage_toggle;
    logic                    probe_current_toggle;
    real                     probe_voltage;
    real                     probe_current;

    logic                    busy;
    logic [CNT_W-1:0]        sample_count;

    modport master (
        output req_valid, req_kind, req_node, rsp_ready, probe_voltage, probe_current,
        input  req_ready, rsp_valid, rsp_id, rsp_kind, rsp_value,
        input  probe_node, probe_voltage_toggle, probe_current_toggle, busy, sample_count
    );

    modport slave (
        input  req_valid, req_kind, req_node, rsp_ready, probe_voltage, probe_current,
        output req_ready, rsp_valid, rsp_id, rsp_kind, rsp_value,
        output probe_node, probe_voltage_toggle, probe_current_toggle, busy, sample_count
    );
endinterface

// File: rtl/analog_probe_scheduler.sv
// Round-robin scheduler sharing one analog probe among N_REQ requesters:
// grant, toggle the probe, wait a settle window, capture and return the value.
module analog_probe_scheduler #(
    parameter int N_REQ         = 4,
    parameter int NODE_W        = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    analog_probe_scheduler_if.slave   bus
);
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ID_W-1:0]   LAST_INIT   = ID_W'(N_REQ - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SETTLE  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                kind_q, kind_d;
    logic [NODE_W-1:0]   probe_node_q, probe_node_d;
    logic                vtog_q, vtog_d;
    logic                ctog_q, ctog_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_kind_q, rsp_kind_d;
    real                 rsp_value_q, rsp_value_d;
    logic [CNT_W-1:0]    sample_count_q, sample_count_d;

    logic [NODE_W-1:0]   node_arr [N_REQ];
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;
    logic [N_REQ-1:0]    grant_oh;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_node
            assign node_arr[gi] = bus.req_node[gi*NODE_W +: NODE_W];
        end
    endgenerate

    // Search upward from the requester after the last one served, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(last_grant_q) + off) % N_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Grant is gated by reset so req_ready drops asynchronously with it.
    always_comb begin
        grant_oh = '0;
        if (reset_n && (state_q == IDLE) && win_found) begin
            grant_oh[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        id_d           = id_q;
        kind_d         = kind_q;
        probe_node_d   = probe_node_q;
        vtog_d         = vtog_q;
        ctog_d         = ctog_q;
        scnt_d         = scnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_kind_d     = rsp_kind_q;
        rsp_value_d    = rsp_value_q;
        sample_count_d = sample_count_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d         = win_id;
                    kind_d       = bus.req_kind[win_id];
                    probe_node_d = node_arr[win_id];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (kind_q) begin
                    ctog_d = ~ctog_q;
                end else begin
                    vtog_d = ~vtog_q;
                end
                scnt_d  = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                scnt_d = scnt_q + SCNT_W'(1);
                if (scnt_q == SETTLE_LAST) begin
                    rsp_value_d = kind_q ? bus.probe_current : bus.probe_voltage;
                    rsp_id_d    = id_q;
                    rsp_kind_d  = kind_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d    = 1'b0;
                    sample_count_d = sample_count_q + CNT_W'(1);
                    last_grant_d   = id_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_grant_q   <= LAST_INIT;
            id_q           <= '0;
            kind_q         <= 1'b0;
            probe_node_q   <= '0;
            vtog_q         <= 1'b0;
            ctog_q         <= 1'b0;
            scnt_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_kind_q     <= 1'b0;
            rsp_value_q    <= 0.0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            id_q           <= id_d;
            kind_q         <= kind_d;
            probe_node_q   <= probe_node_d;
            vtog_q         <= vtog_d;
            ctog_q         <= ctog_d;
            scnt_q         <= scnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_kind_q     <= rsp_kind_d;
            rsp_value_q    <= rsp_value_d;
            sample_count_q <= sample_count_d;
        end
    end

    assign bus.req_ready            = grant_oh;
    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_id               = rsp_id_q;
    assign bus.rsp_kind             = rsp_kind_q;
    assign bus.rsp_value            = rsp_value_q;
    assign bus.probe_node           = probe_node_q;
    assign bus.probe_voltage_toggle = vtog_q;
    assign bus.probe_current_toggle = ctog_q;
    assign bus.busy                 = (state_q != IDLE);
    assign bus.sample_count         = sample_count_q;
endmodule

// File: tb/tb_analog_probe_scheduler.sv
// Directed bench for analog_probe_scheduler: vector table for single requests,
// plus round robin, backpressure, mid-settle reset and counter wrap sequences.
module tb_analog_probe_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_vt = 1'b0;
    logic exp_ct = 1'b0;
    int   exp_cnt = 0;

    analog_probe_scheduler_if #(.N_REQ(4), .NODE_W(4), .CNT_W(8)) bus ();

    analog_probe_scheduler #(
        .N_REQ(4), .NODE_W(4), .SETTLE_CYCLES(2), .CNT_W(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       kind;
        logic [3:0] node;
        real        pv;
        real        pc;
        logic [3:0] exp_ready;
        real        exp_value;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    task automatic chk_toggles(input string name);
        chk({name, "_vtog"}, bus.probe_voltage_toggle, exp_vt);
        chk({name, "_ctog"}, bus.probe_current_toggle, exp_ct);
    endtask

    task automatic quiet_inputs();
        bus.req_valid     = '0;
        bus.req_kind      = '0;
        bus.req_node      = '0;
        bus.rsp_ready     = 1'b0;
        bus.probe_voltage = 0.0;
        bus.probe_current = 0.0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_vt  = 1'b0;
        exp_ct  = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_rsp(input string name);
        int t = 0;
        while (!bus.rsp_valid && t < 12) begin
            tick();
            t++;
        end
        chk({name, "_rsp_timeout"}, bus.rsp_valid, 1'b1);
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (bus.req_ready == 4'b0 && t < 12) begin
            tick();
            t++;
        end
        chk({name, "_ready_timeout"}, bus.req_ready != 4'b0, 1'b1);
    endtask

    task automatic reset_state_checks(input string name);
        chk({name, "_req_ready"}, bus.req_ready, 4'b0);
        chk({name, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        chk({name, "_rsp_id"}, bus.rsp_id, 2'd0);
        chk({name, "_rsp_kind"}, bus.rsp_kind, 1'b0);
        chk_real({name, "_rsp_value"}, bus.rsp_value, 0.0);
        chk({name, "_probe_node"}, bus.probe_node, 4'd0);
        chk({name, "_vtog"}, bus.probe_voltage_toggle, 1'b0);
        chk({name, "_ctog"}, bus.probe_current_toggle, 1'b0);
        chk({name, "_busy"}, bus.busy, 1'b0);
        chk({name, "_count"}, bus.sample_count, 8'd0);
    endtask

    initial begin
        int rr_exp [6];
        int e;
        logic [3:0] oh;

        vecs[0] = '{id: 2, kind: 1'b0, node: 4'd5,  pv: 1.25, pc: 0.3,    exp_ready: 4'b0100, exp_value: 1.25};
        vecs[1] = '{id: 0, kind: 1'b1, node: 4'd15, pv: -1.0, pc: 0.004,  exp_ready: 4'b0001, exp_value: 0.004};
        vecs[2] = '{id: 3, kind: 1'b0, node: 4'd0,  pv: 3.3,  pc: 7.0,    exp_ready: 4'b1000, exp_value: 3.3};
        vecs[3] = '{id: 1, kind: 1'b1, node: 4'd9,  pv: 0.1,  pc: -0.75,  exp_ready: 4'b0010, exp_value: -0.75};
        vecs[4] = '{id: 3, kind: 1'b1, node: 4'd12, pv: 2.0,  pc: 0.125,  exp_ready: 4'b1000, exp_value: 0.125};

        quiet_inputs();
        #1;
        reset_state_checks("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_busy", bus.busy, 1'b0);

        // Single-requester vectors: latency, toggles, capture and hold.
        for (int i = 0; i < 5; i++) begin
            bus.probe_voltage = vecs[i].pv;
            bus.probe_current = vecs[i].pc;
            bus.req_node      = '0;
            bus.req_node[vecs[i].id*4 +: 4] = vecs[i].node;
            bus.req_kind      = '0;
            bus.req_kind[vecs[i].id] = vecs[i].kind;
            bus.req_valid     = '0;
            bus.req_valid[vecs[i].id] = 1'b1;
            bus.rsp_ready     = 1'b0;
            #1;
            chk("vec_req_ready", bus.req_ready, vecs[i].exp_ready);
            tick();
            bus.req_valid = '0;
            chk("vec_probe_node", bus.probe_node, vecs[i].node);
            chk("vec_busy", bus.busy, 1'b1);
            chk_toggles("vec_e0");
            tick();
            if (vecs[i].kind) exp_ct = ~exp_ct; else exp_vt = ~exp_vt;
            chk_toggles("vec_e1");
            tick();
            chk("vec_rsp_early", bus.rsp_valid, 1'b0);
            tick();
            chk("vec_rsp_valid", bus.rsp_valid, 1'b1);
            chk_real("vec_rsp_value", bus.rsp_value, vecs[i].exp_value);
            chk("vec_rsp_id", bus.rsp_id, vecs[i].id);
            chk("vec_rsp_kind", bus.rsp_kind, vecs[i].kind);
            bus.probe_voltage = 99.0;
            bus.probe_current = -99.0;
            tick();
            chk("vec_rsp_hold", bus.rsp_valid, 1'b1);
            chk_real("vec_value_hold", bus.rsp_value, vecs[i].exp_value);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            exp_cnt++;
            chk("vec_consumed", bus.rsp_valid, 1'b0);
            chk("vec_idle", bus.busy, 1'b0);
            chk("vec_count", bus.sample_count, exp_cnt);
            $display("vec %0d: id=%0d kind=%0d node=%0d value=%f count=%0d",
                     i, vecs[i].id, vecs[i].kind, vecs[i].node, bus.rsp_value, bus.sample_count);
        end

        // Round robin with every requester valid and rsp_ready held high.
        do_reset();
        rr_exp = '{0, 1, 2, 3, 0, 1};
        bus.req_valid     = 4'hF;
        bus.req_kind      = 4'b1010;
        bus.req_node      = {4'd7, 4'd5, 4'd3, 4'd1};
        bus.probe_voltage = 2.5;
        bus.probe_current = 0.01;
        bus.rsp_ready     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = rr_exp[k];
            #1;
            wait_ready("rr");
            oh = 4'b0001 << e;
            chk("rr_grant", bus.req_ready, oh);
            tick();
            chk("rr_node", bus.probe_node, 2 * e + 1);
            tick();
            if (e % 2 == 1) exp_ct = ~exp_ct; else exp_vt = ~exp_vt;
            chk_toggles("rr");
            wait_rsp("rr");
            chk("rr_rsp_id", bus.rsp_id, e);
            chk("rr_rsp_kind", bus.rsp_kind, e % 2);
            chk_real("rr_rsp_value", bus.rsp_value, (e % 2 == 1) ? 0.01 : 2.5);
            tick();
            if (k == 5) bus.req_valid = '0;
            exp_cnt++;
            chk("rr_count", bus.sample_count, exp_cnt);
            $display("rr %0d: grant=%0d rsp_id=%0d count=%0d", k, e, bus.rsp_id, bus.sample_count);
        end
        bus.rsp_ready = 1'b0;

        // Backpressure: response held while the probe value moves.
        bus.req_valid     = 4'b0010;
        bus.req_kind      = 4'b0010;
        bus.req_node      = {4'd0, 4'd0, 4'd3, 4'd0};
        bus.probe_current = -0.002;
        #1;
        chk("bp_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b1101;
        chk("bp_node", bus.probe_node, 4'd3);
        tick();
        exp_ct = ~exp_ct;
        chk_toggles("bp");
        tick();
        tick();
        chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
        chk_real("bp_value", bus.rsp_value, -0.002);
        bus.probe_current = 0.5;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", bus.rsp_valid, 1'b1);
            chk_real("bp_hold_value", bus.rsp_value, -0.002);
            chk("bp_no_grant", bus.req_ready, 4'b0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        chk("bp_consumed", bus.rsp_valid, 1'b0);
        chk("bp_idle", bus.busy, 1'b0);
        chk("bp_next_grant", bus.req_ready, 4'b0100);
        chk("bp_count", bus.sample_count, exp_cnt);
        bus.req_valid = '0;
        $display("bp: value=%f count=%0d", bus.rsp_value, bus.sample_count);

        // Reset while requester 3 is settling, then resume.
        bus.req_valid     = 4'b1000;
        bus.req_kind      = 4'b0000;
        bus.req_node      = {4'd6, 4'd0, 4'd0, 4'd2};
        bus.probe_voltage = 4.5;
        #1;
        chk("rs_ready3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("rs_in_settle", bus.busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        reset_state_checks("rs_async");
        exp_vt = 1'b0;
        exp_ct = 1'b0;
        exp_cnt = 0;
        tick();
        bus.req_valid = 4'b1001;
        #1;
        chk("rs_ready_in_reset", bus.req_ready, 4'b0);
        reset_n = 1'b1;
        #1;
        chk("rs_first_grant", bus.req_ready, 4'b0001);
        chk("rs_no_stale", bus.rsp_valid, 1'b0);
        tick();
        bus.req_valid = 4'b1000;
        chk("rs_node", bus.probe_node, 4'd2);
        tick();
        exp_vt = ~exp_vt;
        chk_toggles("rs");
        chk("rs_no_stale_e1", bus.rsp_valid, 1'b0);
        tick();
        chk("rs_no_stale_e2", bus.rsp_valid, 1'b0);
        tick();
        chk("rs_rsp_valid", bus.rsp_valid, 1'b1);
        chk("rs_rsp_id", bus.rsp_id, 2'd0);
        chk_real("rs_rsp_value", bus.rsp_value, 4.5);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        chk("rs_count", bus.sample_count, exp_cnt);
        chk("rs_second_grant", bus.req_ready, 4'b1000);
        bus.req_valid = '0;
        $display("rs: resumed id=%0d count=%0d", bus.rsp_id, bus.sample_count);

        // Counter wrap over 257 back-to-back responses.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        for (int r = 1; r <= 257; r++) begin
            wait_rsp("wrap");
            if (!bus.rsp_valid) break;
            tick();
            exp_cnt = (exp_cnt + 1) % 256;
            if (r >= 255) begin
                chk("wrap_count", bus.sample_count, exp_cnt);
                $display("wrap: response %0d count=%0d", r, bus.sample_count);
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
